// File: rtl/clk_enable_ctrl_pkg.sv
// Shared command and FSM state encodings for the clock-enable controller.
package clk_enable_ctrl_pkg;

  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_RUN  = 2'd1;
  localparam logic [1:0] CMD_STEP = 2'd2;
  localparam logic [1:0] CMD_STOP = 2'd3;

  localparam logic [1:0] CEC_IDLE     = 2'd0;
  localparam logic [1:0] CEC_RUN      = 2'd1;
  localparam logic [1:0] CEC_STEP     = 2'd2;
  localparam logic [1:0] CEC_STOPPING = 2'd3;

  // Only RUN and STEP compete for ownership; NOP/STOP in IDLE are just absorbed.
  function automatic logic is_start(input logic [1:0] cmd);
    return (cmd == CMD_RUN) || (cmd == CMD_STEP);
  endfunction

endpackage

// File: rtl/clk_enable_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from a rotating priority pointer.
// Pointer moves past the winner only when the caller strobes adv_i.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  // Scan from the farthest slot back to the pointer so the nearest request wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_q) + k) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_q) + k) % N] = 1'b1;
        idx_o = IW'((int'(ptr_q) + k) % N);
        vld_o = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && vld_o) begin
      ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/clk_enable_ctrl.sv
// Shares the core clk_enable among requesters issuing RUN / STEP(n) / STOP commands.
// All outputs registered: a command seen in cycle t is acked and acted on at t+1.
module clk_enable_ctrl
  import clk_enable_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int CNT_W   = 16,
  localparam int OW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_cmd,
  input  logic [CNT_W*NUM_REQ-1:0] req_count,
  input  logic                     core_idle,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic                     clk_enable,
  output logic [OW-1:0]            owner,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         steps_left
);

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic               clk_en_q, clk_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [NUM_REQ-1:0] vld_eff, start_req, other_req, other_oh, own_oh;
  logic [NUM_REQ-1:0] arb_req, arb_gnt;
  logic [OW-1:0]      arb_idx;
  logic               arb_vld, idle_open, own_vld;
  logic [1:0]         arb_cmd, own_cmd;
  logic [CNT_W-1:0]   arb_cnt;

  // A requester still shows valid in its ack cycle; that echo is not a new command.
  always_comb begin
    vld_eff   = req_valid & ~ack_q;
    start_req = '0;
    other_oh  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      start_req[i] = vld_eff[i] && is_start(req_cmd[2*i +: 2]);
    end
    other_req = vld_eff & ~start_req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (other_req[i]) begin
        other_oh    = '0;
        other_oh[i] = 1'b1;
      end
    end
  end

  // One decision per two cycles in IDLE keeps acks spaced apart.
  assign idle_open = (state_q == CEC_IDLE) && (ack_q == '0);
  assign arb_req   = idle_open ? start_req : '0;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i (arb_req),
    .adv_i (idle_open),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  assign arb_cmd = req_cmd[2*int'(arb_idx) +: 2];
  assign arb_cnt = req_count[CNT_W*int'(arb_idx) +: CNT_W];
  assign own_cmd = req_cmd[2*int'(owner_q) +: 2];
  assign own_vld = vld_eff[owner_q];
  assign own_oh  = NUM_REQ'(1) << owner_q;

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    done_d  = 1'b0;
    owner_d = owner_q;
    steps_d = steps_q;
    case (state_q)
      CEC_IDLE: begin
        if (arb_vld) begin
          ack_d   = arb_gnt;
          owner_d = arb_idx;
          if (arb_cmd == CMD_RUN) begin
            state_d = CEC_RUN;
          end else if (arb_cnt != '0) begin
            state_d = CEC_STEP;
            steps_d = arb_cnt;
          end else begin
            done_d = 1'b1;
          end
        end else if (idle_open) begin
          ack_d = other_oh;
        end
      end
      CEC_RUN: begin
        if (own_vld) begin
          ack_d = own_oh;
          if (own_cmd == CMD_STOP) state_d = CEC_STOPPING;
        end
      end
      CEC_STEP: begin
        if (own_vld) ack_d = own_oh;
        if ((own_vld && own_cmd == CMD_STOP) || steps_q == CNT_W'(1)) begin
          state_d = CEC_IDLE;
          done_d  = 1'b1;
          steps_d = '0;
        end else begin
          steps_d = steps_q - CNT_W'(1);
        end
      end
      default: begin
        if (core_idle) begin
          state_d = CEC_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
    busy_d   = (state_d != CEC_IDLE);
    clk_en_d = (state_d != CEC_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CEC_IDLE;
      ack_q    <= '0;
      owner_q  <= '0;
      steps_q  <= '0;
      clk_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      owner_q  <= owner_d;
      steps_q  <= steps_d;
      clk_en_q <= clk_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign req_ack    = ack_q;
  assign clk_enable = clk_en_q;
  assign owner      = owner_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = steps_q;

endmodule

// File: tb/tb_clk_enable_ctrl.sv
// Directed and random stimulus for clk_enable_ctrl, checked every cycle against a session-level model.
module tb_clk_enable_ctrl;
  localparam int N  = 2;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_cmd;
  logic [CW*N-1:0] req_count;
  logic            core_idle;
  logic [N-1:0]    req_ack;
  logic            clk_enable;
  logic [0:0]      owner;
  logic            busy;
  logic            done;
  logic [CW-1:0]   steps_left;

  always #5 clk = ~clk;

  clk_enable_ctrl #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_cmd    (req_cmd),
    .req_count  (req_count),
    .core_idle  (core_idle),
    .req_ack    (req_ack),
    .clk_enable (clk_enable),
    .owner      (owner),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: a session is idle, free-running, counted (ends at cycle m_end) or draining.
  int       m_mode  = 0;
  int       m_owner = 0;
  int       m_ptr   = 0;
  int       m_end   = 0;
  logic [N-1:0] e_ack  = '0;
  logic         e_done = 1'b0;
  logic [N-1:0] drop_next = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int cmd_of(input int i);
    logic [2*N-1:0] c;
    c = req_cmd;
    return int'(c[2*i +: 2]);
  endfunction

  function automatic int cnt_of(input int i);
    logic [CW*N-1:0] c;
    c = req_count;
    return int'(c[CW*i +: CW]);
  endfunction

  task automatic model_edge();
    logic [N-1:0] eff, nack;
    logic ndone;
    int w;
    eff   = req_valid & ~e_ack;
    nack  = '0;
    ndone = 1'b0;
    if (reset) begin
      m_mode = 0; m_ptr = 0; m_owner = 0;
    end else begin
      case (m_mode)
        0: if (e_ack == '0) begin
          w = -1;
          for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (w < 0 && eff[j] && (cmd_of(j) == 1 || cmd_of(j) == 2)) w = j;
          end
          if (w >= 0) begin
            nack[w] = 1'b1;
            m_ptr   = (w + 1) % N;
            m_owner = w;
            if (cmd_of(w) == 1) m_mode = 1;
            else if (cnt_of(w) > 0) begin m_mode = 2; m_end = cyc + 1 + cnt_of(w); end
            else ndone = 1'b1;
          end else begin
            for (int j = 0; j < N; j++) if (eff[j] && nack == '0) nack[j] = 1'b1;
          end
        end
        1: if (eff[m_owner]) begin
          nack[m_owner] = 1'b1;
          if (cmd_of(m_owner) == 3) m_mode = 3;
        end
        2: begin
          if (eff[m_owner]) nack[m_owner] = 1'b1;
          if ((eff[m_owner] && cmd_of(m_owner) == 3) || (m_end - cyc == 1)) begin
            m_mode = 0; ndone = 1'b1;
          end
        end
        default: if (core_idle) begin m_mode = 0; ndone = 1'b1; end
      endcase
    end
    e_ack  = nack;
    e_done = ndone;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    chk("ack",   32'(req_ack),    32'(e_ack));
    chk("done",  32'(done),       32'(e_done));
    chk("busy",  32'(busy),       32'(m_mode != 0));
    chk("clken", 32'(clk_enable), 32'(m_mode != 0));
    chk("steps", 32'(steps_left), (m_mode == 2) ? 32'(m_end - cyc) : 32'd0);
    if (m_mode != 0) chk("owner", 32'(owner), 32'(m_owner));
    for (int i = 0; i < N; i++) if (drop_next[i]) req_valid[i] = 1'b0;
    drop_next = e_ack;
  endtask

  task automatic issue(input int i, input int cmd, input int cnt);
    req_valid[i]           = 1'b1;
    req_cmd[2*i +: 2]      = 2'(cmd);
    req_count[CW*i +: CW]  = CW'(cnt);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_cmd = '0; req_count = '0; core_idle = 1'b0;
    ticks(3);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_clken", 32'(clk_enable), 32'd0);
    reset = 1'b0;
    tick();

    // RUN grant latency, STOP with core busy, then drain
    issue(0, 1, 0);
    tick();
    chk("run_ack0", 32'(req_ack), 32'b01);
    chk("run_owner", 32'(owner), 32'd0);
    tick();
    issue(0, 3, 0);
    tick();
    ticks(3);
    chk("stopping_busy", 32'(busy), 32'd1);
    core_idle = 1'b1;
    tick();
    chk("drain_done", 32'(done), 32'd1);
    chk("drain_clken", 32'(clk_enable), 32'd0);
    core_idle = 1'b0;
    tick();

    // STEP 5 then STEP 0
    issue(1, 2, 5);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("step5_left", 32'(steps_left), 32'(5 - k));
      chk("step5_clken", 32'(clk_enable), 32'd1);
      tick();
    end
    chk("step5_done", 32'(done), 32'd1);
    tick();
    issue(1, 2, 0);
    tick();
    chk("step0_ack", 32'(req_ack), 32'b10);
    chk("step0_done", 32'(done), 32'd1);
    ticks(2);

    // Both RUN: grants alternate
    core_idle = 1'b1;
    for (int r = 0; r < 4; r++) begin
      if (!req_valid[0]) issue(0, 1, 0);
      if (!req_valid[1]) issue(1, 1, 0);
      tick();
      chk("rr_owner", 32'(owner), 32'(r % 2));
      tick();
      issue(r % 2, 3, 0);
      ticks(2);
    end
    core_idle = 1'b0;

    // Non-owner STOP waits while requester 0 runs
    tick();
    chk("np_owner", 32'(owner), 32'd0);
    tick();
    issue(1, 3, 0);
    ticks(3);
    chk("np_noack", 32'(req_ack), 32'd0);
    issue(0, 3, 0);
    core_idle = 1'b1;
    ticks(2);
    tick();
    chk("np_late_ack", 32'(req_ack), 32'b10);
    chk("np_late_busy", 32'(busy), 32'd0);
    ticks(2);
    core_idle = 1'b0;

    // STEP 100 cut short by owner STOP in its 10th cycle
    issue(0, 2, 100);
    ticks(10);
    issue(0, 3, 0);
    tick();
    chk("cut_ack", 32'(req_ack), 32'b01);
    chk("cut_done", 32'(done), 32'd1);
    chk("cut_left", 32'(steps_left), 32'd0);
    tick();

    // Maximum step count loads intact
    issue(1, 2, 65535);
    tick();
    chk("max_left", 32'(steps_left), 32'd65535);
    tick();
    issue(1, 3, 0);
    ticks(3);

    // Reset mid-STEP
    issue(1, 2, 20);
    ticks(14);
    chk("pre_rst_left", 32'(steps_left), 32'd7);
    reset = 1'b1;
    tick();
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    issue(0, 1, 0);
    issue(1, 1, 0);
    tick();
    chk("post_rst_ack", 32'(req_ack), 32'b01);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      core_idle = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          issue(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
